// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional subtract support is enabled by defining SERIAL_SUB_EN.
package serial_add_ctrl_pkg;

    localparam int SA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow: like-signed operands producing an opposite-signed result.
    function automatic logic ovf_f(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
// Purely combinational.
module full_adder (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = in1 ^ in2 ^ cin;
    assign cout = (in1 & in2) | (in1 & cin) | (in2 & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell iterated LSB first over WIDTH cycles.
// Define SERIAL_SUB_EN to add the sub port (a - b via inverted b and carry-in 1).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] sb_d;
    logic             carry_d;
    logic [WIDTH-1:0] sr_d;
    logic             fa_sum;
    logic             fa_cout;

`ifdef SERIAL_SUB_EN
    always_comb begin
        sb_d    = sub ? ~b : b;
        carry_d = sub;
    end
`else
    always_comb begin
        sb_d    = b;
        carry_d = 1'b0;
    end
`endif

    full_adder u_fa (
        .in1  (sa_q[0]),
        .in2  (sb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign sr_d = {fa_sum, sr_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= sb_d;
                        carry_q <= carry_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sr_q    <= sr_d;
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    carry_q <= fa_cout;
                    if (cnt_q == LAST) begin
                        // MSB step: operand bits still sit at position 0 here
                        sum_q   <= sr_d;
                        cout_q  <= fa_cout;
                        ovf_q   <= ovf_f(sa_q[0], sb_q[0], fa_sum);
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
